// File: rtl/delay_line_ctrl_if.sv
// Stream, control and status bundle for delay_line_ctrl.
// The slave modport is the delay line itself; the master drives it.
interface delay_line_ctrl_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DEPTH  = 16
);
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int W  = NUM_CH * DATA_WIDTH;

  logic          en_in;
  logic          flush_in;
  logic [DW-1:0] delay_sel_in;
  logic          valid_in;
  logic [W-1:0]  data_in;
  logic          ready_out;
  logic          valid_out;
  logic [W-1:0]  data_out;
  logic [DW-1:0] active_delay_out;
  logic          busy_out;
  logic          cfg_err_out;

  modport master (
    output en_in, flush_in, delay_sel_in, valid_in, data_in,
    input  ready_out, valid_out, data_out, active_delay_out, busy_out, cfg_err_out
  );

  modport slave (
    input  en_in, flush_in, delay_sel_in, valid_in, data_in,
    output ready_out, valid_out, data_out, active_delay_out, busy_out, cfg_err_out
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Multi-channel valid-tagged delay line with run-time delay 0..MAX_DEPTH.
// A delay change drains in-flight samples at the old delay before it takes effect.
module delay_line_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_DEPTH   = 16,
  parameter int RESET_DELAY = 4,
  parameter int BYPASS      = 0
) (
  input  logic               clk,
  input  logic               arst_n,
  delay_line_ctrl_if.slave   bus
);
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int W  = NUM_CH * DATA_WIDTH;

  generate
    if (BYPASS != 0) begin : g_bypass
      assign bus.data_out         = bus.data_in;
      assign bus.valid_out        = bus.valid_in;
      assign bus.ready_out        = 1'b1;
      assign bus.busy_out         = 1'b0;
      assign bus.cfg_err_out      = 1'b0;
      assign bus.active_delay_out = '0;
    end else begin : g_pipe
      localparam logic [0:0] RUN   = 1'b0;
      localparam logic [0:0] DRAIN = 1'b1;

      logic [0:0]                   state;
      logic [DW-1:0]                active;
      logic [DW-1:0]                occ;
      logic [DW-1:0]                req;
      logic [MAX_DEPTH-1:0]         vld_pipe;
      logic [MAX_DEPTH-1:0][W-1:0]  data_pipe;
      logic                         over, ready, acc, zero, busy, err;
      logic                         tap_vld, inc, dec, apply;
      logic [W-1:0]                 tap_data;

      assign over  = bus.delay_sel_in > DW'(MAX_DEPTH);
      assign req   = over ? DW'(MAX_DEPTH) : bus.delay_sel_in;
      assign ready = bus.en_in & (state == RUN) & (req == active);
      assign acc   = bus.valid_in & ready;
      assign zero  = (active == '0);
      assign busy  = (occ != '0);

      // Tap mux written as a compare loop so the index width never exceeds the array.
      always_comb begin
        tap_vld  = 1'b0;
        tap_data = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
          if (active == DW'(i + 1)) begin
            tap_vld  = vld_pipe[i];
            tap_data = data_pipe[i];
          end
        end
      end

      assign bus.valid_out = zero ? acc : tap_vld;
      assign bus.data_out  = zero ? (acc ? bus.data_in : '0) : (tap_vld ? tap_data : '0);

      assign inc   = acc & ~zero;
      assign dec   = bus.valid_out & ~zero;
      assign apply = (state == RUN) ? ((req != active) & ~busy) : ~busy;

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          state     <= RUN;
          active    <= DW'(RESET_DELAY);
          occ       <= '0;
          vld_pipe  <= '0;
          data_pipe <= '0;
          err       <= 1'b0;
        end else if (bus.flush_in) begin
          state     <= RUN;
          active    <= req;
          occ       <= '0;
          vld_pipe  <= '0;
          data_pipe <= '0;
          err       <= over;
        end else if (bus.en_in) begin
          err          <= err | over;
          occ          <= occ + DW'(inc) - DW'(dec);
          data_pipe[0] <= bus.data_in;
          for (int i = 1; i < MAX_DEPTH; i++) data_pipe[i] <= data_pipe[i-1];
          if (apply) begin
            // New tap position: stale valids anywhere in the line must not surface.
            active   <= req;
            state    <= RUN;
            vld_pipe <= '0;
          end else begin
            vld_pipe[0] <= acc;
            for (int i = 1; i < MAX_DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (state == RUN && req != active) state <= DRAIN;
          end
        end
      end

      assign bus.ready_out        = ready;
      assign bus.busy_out         = busy;
      assign bus.cfg_err_out      = err;
      assign bus.active_delay_out = active;
    end
  endgenerate
endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl: fixed delay, stall, drain-reconfigure,
// zero delay, clamp error, flush and async reset mid-drain.
module tb_delay_line_ctrl;
  logic clk = 1'b0;
  logic arst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  delay_line_ctrl_if #(.NUM_CH(2), .DATA_WIDTH(16), .MAX_DEPTH(16)) bus ();

  delay_line_ctrl #(
    .NUM_CH(2), .DATA_WIDTH(16), .MAX_DEPTH(16), .RESET_DELAY(4), .BYPASS(0)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c0, s;
    logic [31:0] exp_d;
    logic        exp_v;

    arst_n           = 1'b0;
    bus.en_in        = 1'b0;
    bus.flush_in     = 1'b0;
    bus.delay_sel_in = 5'd4;
    bus.valid_in     = 1'b0;
    bus.data_in      = '0;
    #12;
    check("rst_valid",  bus.valid_out, 0);
    check("rst_data",   bus.data_out, 0);
    check("rst_busy",   bus.busy_out, 0);
    check("rst_active", bus.active_delay_out, 4);
    check("rst_err",    bus.cfg_err_out, 0);
    check("rst_ready0", bus.ready_out, 0);
    bus.en_in = 1'b1;
    #1;
    check("rst_ready1", bus.ready_out, 1);
    #5 arst_n = 1'b1;
    tick();

    // fixed delay 4, ch1 = -ch0
    for (int k = 0; k < 20; k++) begin
      bus.valid_in = (k < 16);
      c0 = 16'(k + 1);
      bus.data_in = {-c0, c0};
      #1;
      exp_v = (k >= 4);
      s = 16'(k - 3);
      exp_d = exp_v ? {-s, s} : 32'h0;
      check("fix_valid", bus.valid_out, exp_v);
      check("fix_data",  bus.data_out, exp_d);
      if (k == 0) check("fix_ready", bus.ready_out, 1);
      if (k == 4) check("fix_ch1_first", bus.data_out[31:16], 16'hFFFF);
      tick();
    end
    bus.valid_in = 1'b0;
    #1;
    check("fix_busy_end", bus.busy_out, 0);

    // stall with d=3
    bus.delay_sel_in = 5'd3;
    #1;
    check("stl_apply_ready", bus.ready_out, 0);
    tick();
    #1;
    check("stl_active", bus.active_delay_out, 3);
    check("stl_ready",  bus.ready_out, 1);
    bus.valid_in = 1'b1;
    bus.data_in  = 32'h1234_5678;
    tick();
    bus.valid_in = 1'b0;
    bus.en_in    = 1'b0;
    #1;
    check("stl_busy_t1",  bus.busy_out, 1);
    check("stl_ready_t1", bus.ready_out, 0);
    tick();
    #1;
    check("stl_busy_t2",  bus.busy_out, 1);
    check("stl_valid_t2", bus.valid_out, 0);
    tick();
    bus.en_in = 1'b1;
    #1;
    check("stl_valid_t3", bus.valid_out, 0);
    tick();
    #1;
    check("stl_valid_t4", bus.valid_out, 0);
    tick();
    #1;
    check("stl_valid_t5", bus.valid_out, 1);
    check("stl_data_t5",  bus.data_out, 32'h1234_5678);
    check("stl_busy_t5",  bus.busy_out, 1);
    tick();
    #1;
    check("stl_busy_t6", bus.busy_out, 0);

    // reconfigure 8 -> 2 with 5 samples in flight
    bus.delay_sel_in = 5'd8;
    tick();
    for (int k = 0; k < 14; k++) begin
      if (k < 5) begin
        bus.valid_in = 1'b1;
        bus.data_in  = {16'h0, 16'(16'h10 + k)};
      end else begin
        bus.delay_sel_in = 5'd2;
        bus.valid_in     = 1'b1;
        bus.data_in      = 32'hDEAD_BEEF;
      end
      #1;
      if (k >= 5) check("drn_ready", bus.ready_out, 0);
      exp_v = (k >= 8 && k <= 12);
      exp_d = exp_v ? {16'h0, 16'(16'h10 + k - 8)} : 32'h0;
      check("drn_valid", bus.valid_out, exp_v);
      check("drn_data",  bus.data_out, exp_d);
      tick();
    end
    bus.data_in = 32'hCAFE_0002;
    #1;
    check("drn_active", bus.active_delay_out, 2);
    check("drn_ready1", bus.ready_out, 1);
    check("drn_valid14", bus.valid_out, 0);
    tick();
    bus.valid_in = 1'b0;
    #1;
    check("d2_valid15", bus.valid_out, 0);
    tick();
    #1;
    check("d2_valid16", bus.valid_out, 1);
    check("d2_data16",  bus.data_out, 32'hCAFE_0002);
    tick();

    // zero delay
    bus.delay_sel_in = 5'd0;
    #1;
    check("z_busy_pre",  bus.busy_out, 0);
    check("z_ready_pre", bus.ready_out, 0);
    tick();
    bus.valid_in = 1'b1;
    bus.data_in  = 32'h8000_7FFF;
    #1;
    check("z_valid", bus.valid_out, 1);
    check("z_data",  bus.data_out, 32'h8000_7FFF);
    check("z_ready", bus.ready_out, 1);
    tick();
    bus.valid_in = 1'b0;
    bus.data_in  = 32'h1111_2222;
    #1;
    check("z_valid_lo", bus.valid_out, 0);
    check("z_data_lo",  bus.data_out, 0);
    check("z_busy",     bus.busy_out, 0);

    // out of range clamp and flush
    bus.delay_sel_in = 5'd20;
    #1;
    check("oor_ready", bus.ready_out, 0);
    tick();
    #1;
    check("oor_err",    bus.cfg_err_out, 1);
    check("oor_active", bus.active_delay_out, 16);
    bus.delay_sel_in = 5'd16;
    tick();
    #1;
    check("oor_sticky", bus.cfg_err_out, 1);
    bus.flush_in     = 1'b1;
    bus.delay_sel_in = 5'd5;
    tick();
    bus.flush_in = 1'b0;
    #1;
    check("fl_err_clr", bus.cfg_err_out, 0);
    check("fl_active5", bus.active_delay_out, 5);
    bus.flush_in     = 1'b1;
    bus.delay_sel_in = 5'd17;
    tick();
    bus.flush_in = 1'b0;
    #1;
    check("fl_reflag",   bus.cfg_err_out, 1);
    check("fl_active16", bus.active_delay_out, 16);
    bus.flush_in     = 1'b1;
    bus.delay_sel_in = 5'd5;
    tick();
    bus.flush_in = 1'b0;
    #1;
    check("fl_err_clr2", bus.cfg_err_out, 0);

    // flush with 3 in flight, d=5
    for (int k = 0; k < 3; k++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = 32'(32'hA1 + k);
      tick();
    end
    bus.flush_in = 1'b1;
    bus.data_in  = 32'hA4;
    #1;
    check("fl_busy_pre", bus.busy_out, 1);
    tick();
    bus.flush_in = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    check("fl_busy_post",  bus.busy_out, 0);
    check("fl_valid_post", bus.valid_out, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      check("fl_quiet", bus.valid_out, 0);
    end

    // async reset in the middle of a drain
    bus.valid_in = 1'b1;
    bus.data_in  = 32'h0000_00B1;
    tick();
    bus.data_in  = 32'h0000_00B2;
    tick();
    bus.valid_in     = 1'b0;
    bus.delay_sel_in = 5'd9;
    #1;
    check("ar_ready_c2", bus.ready_out, 0);
    tick();
    bus.delay_sel_in = 5'd5;
    #1;
    check("ar_ready_drain", bus.ready_out, 0);
    tick();
    tick();
    #1;
    check("ar_valid_pre", bus.valid_out, 1);
    check("ar_data_pre",  bus.data_out, 32'h0000_00B1);
    #1 arst_n = 1'b0;
    #1;
    check("ar_valid",  bus.valid_out, 0);
    check("ar_data",   bus.data_out, 0);
    check("ar_busy",   bus.busy_out, 0);
    check("ar_active", bus.active_delay_out, 4);
    check("ar_err",    bus.cfg_err_out, 0);
    #3 arst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
Multi-channel, valid-tagged delay line with a run-time selectable delay of 0..MAX_DEPTH cycles, stall (enable), synchronous flush and backpressure during delay reconfiguration. It is the parametrised successor of the fixed-depth data pipeline used in the FFT datapath. Typical use: aligning twiddle/control streams against butterfly outputs when the stage latency differs by FFT mode.

Parameters:
NUM_CH, 2, number of parallel data channels sharing one valid/delay
DATA_WIDTH, 16, signed width of each channel
MAX_DEPTH, 16, number of physical stages (maximum delay); must be >= 1
RESET_DELAY, 4, active delay loaded at reset; must be <= MAX_DEPTH
BYPASS, 0, when 1 the block is a pure wire (no registers)

Ports:
clk  in  1  clock, all logic on rising edge
arst_n  in  1  asynchronous active-low reset
en_in  in  1  global advance; 0 freezes all state
flush_in  in  1  synchronous clear of contents, FSM and error flag
delay_sel_in  in  DW=$clog2(MAX_DEPTH+1)  requested delay, in cycles
valid_in  in  1  input sample valid
data_in  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
ready_out  out  1  block accepts input this cycle
valid_out  out  1  output sample valid
data_out  out  NUM_CH*DATA_WIDTH  delayed data; zero when valid_out=0
active_delay_out  out  DW  delay currently in force
busy_out  out  1  one or more valid samples in flight
cfg_err_out  out  1  sticky: delay_sel_in exceeded MAX_DEPTH

Behaviour:
- Reset (async, arst_n=0): all data and valid stages = 0; occupancy = 0; FSM = RUN; active_delay = RESET_DELAY; cfg_err_out = 0. Consequently valid_out = 0, data_out = 0, busy_out = 0, and ready_out follows en_in.
- Clamping: req = min(delay_sel_in, MAX_DEPTH). If delay_sel_in > MAX_DEPTH while en_in=1 or flush_in=1, cfg_err_out is set at that edge and held until flush_in or reset.
- Accept: acc = valid_in & ready_out. ready_out = en_in & (state==RUN) & (req==active_delay).
- Shift, on an edge with en_in=1 and flush_in=0: stage[0] <= {acc, data_in}; stage[i] <= stage[i-1]. The data regs load regardless of valid.
- Tap: for d = active_delay >= 1, valid_out = stage[d-1].valid and data_out = stage[d-1].data masked by valid. A sample accepted in cycle t appears in cycle t+d, plus one cycle per intervening en_in=0 cycle.
- d = 0: combinational pass-through, valid_out = acc, data_out = data_in masked by acc.
- Occupancy counter (width DW): +1 on acc when d>=1; -1 when valid_out & en_in & d>=1; both at once leaves it unchanged. busy_out = (occupancy != 0).
- FSM RUN: if en_in and req != active_delay:
  - busy_out = 0: active_delay <= req at that edge, all valid bits cleared, stay RUN. Input is blocked for that one cycle.
  - busy_out = 1: go to DRAIN.
- FSM DRAIN: ready_out = 0 and bubbles are shifted in. When occupancy reaches 0 (sampled with en_in=1), active_delay <= the current req, all valid bits are cleared, and the FSM returns to RUN.
  - If delay_sel_in returns to active_delay during DRAIN, draining still completes before returning to RUN.
- Flush (flush_in=1 at an edge), priority over en_in and FSM:
  - clears all valid bits, data regs, occupancy and cfg_err_out;
  - FSM = RUN and active_delay <= req;
  - a sample presented in the flush cycle is discarded;
  - the clamp error for the flush cycle itself is re-flagged.
- en_in=0: no state changes except flush; outputs hold their current values; ready_out = 0.
- BYPASS=1: data_out = data_in, valid_out = valid_in, ready_out = 1, busy_out = 0, cfg_err_out = 0, active_delay_out = 0; all other inputs are ignored.
- Arithmetic: none on data. Channels are carried bit-exact, sign preserved.

Test Plan:
- Reset then fixed delay: RESET_DELAY=4; drive a sample every cycle, ch0 = 0x0001..0x0010, ch1 = negated -> valid_out first high exactly 4 cycles after the first accept, with values in order and bit-exact (ch1 = 0xFFFF for the first sample).
- Stall: d=3; accept A at t0, en_in=0 for cycles t1–t2 -> A on data_out at t5; busy_out stays 1 throughout the stall.
- Reconfigure while busy: d=8 with 5 samples in flight, set delay_sel_in=2 -> ready_out=0, all 5 samples emerge at 8-cycle latency, then active_delay_out=2 and ready_out=1. The next sample has 2-cycle latency.
- Zero delay: set delay_sel_in=0 while empty -> after the one-cycle apply, valid_out/data_out mirror valid_in/data_in combinationally; occupancy stays 0.
- Out of range: MAX_DEPTH=16, delay_sel_in=20 -> cfg_err_out=1 and active_delay_out=16. A flush with delay_sel_in=5 -> cfg_err_out=0 and active_delay_out=5.
- Flush and async reset mid-stream: flush with 3 samples in flight -> valid_out=0 next cycle and busy_out=0. Assert arst_n=0 mid-DRAIN -> outputs zero immediately and active_delay_out=RESET_DELAY.
